// File: rtl/sqrt_fx_iter.sv
// sqrt_fx_iter: iterative restoring fixed-point square root, BPC root bits per cycle, optional rounding and sign check.
module sqrt_fx_iter #(
  parameter int WIDTH  = 16,
  parameter int FBITS  = 8,
  parameter int BPC    = 1,
  parameter int ROUND  = 0,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] rad,
  output logic             busy,
  output logic             valid,
  output logic             err,
  output logic [WIDTH-1:0] root,
  output logic [WIDTH-1:0] rem
);
  localparam int XW   = WIDTH + FBITS;
  localparam int ITER = XW / 2;
  localparam int C    = ITER / BPC;
  localparam int RW   = ITER + 2;
  localparam int TW   = RW + 2;
  localparam int CW   = $clog2(C + 1);
  typedef enum logic [1:0] {IDLE, CALC, RND, DONE} state_t;
  state_t r_state;
  logic [XW-1:0] r_x, w_x;
  logic [RW-1:0] r_rem, w_rem;
  logic [ITER-1:0] r_root, w_root, w_rnd;
  logic [TW-1:0] w_cat, w_trial;
  logic [CW-1:0] r_cnt;
  logic r_neg, w_go, w_up;
  always_comb begin
    w_x = r_x;
    w_rem = r_rem;
    w_root = r_root;
    w_cat = '0;
    w_trial = '0;
    for (int k = 0; k < BPC; k++) begin
      w_cat = {w_rem, w_x[XW-1 -: 2]};
      w_trial = w_cat - TW'({w_root, 2'b01});
      w_rem = w_trial[TW-1] ? RW'(w_cat) : RW'(w_trial);
      w_root = {w_root[ITER-2:0], ~w_trial[TW-1]};
      w_x = w_x << 2;
    end
  end
  // round up when the remainder exceeds the root, i.e. X lies above (r+0.5)^2
  assign w_up  = (RW'(r_root) < r_rem) && !(&r_root);
  assign w_rnd = r_root + ITER'(w_up);
  assign w_go  = start && (r_state == IDLE || r_state == DONE);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_x <= '0;
      r_rem <= '0;
      r_root <= '0;
      r_cnt <= '0;
      r_neg <= 1'b0;
      busy <= 1'b0;
      valid <= 1'b0;
      err <= 1'b0;
      root <= '0;
      rem <= '0;
    end else begin
      valid <= 1'b0;
      if (w_go) begin
        r_state <= CALC;
        busy <= 1'b1;
        r_x <= XW'(rad) << FBITS;
        r_rem <= '0;
        r_root <= '0;
        r_cnt <= CW'(C - 1);
        r_neg <= (SIGNED != 0) && rad[WIDTH-1];
      end else if (r_state == DONE) begin
        r_state <= IDLE;
      end else if (r_state == CALC && r_neg) begin
        r_state <= DONE;
        busy <= 1'b0;
        valid <= 1'b1;
        err <= 1'b1;
        root <= '0;
        rem <= '0;
      end else if (r_state == CALC) begin
        r_x <= w_x;
        r_rem <= w_rem;
        r_root <= w_root;
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == '0) begin
          if (ROUND != 0) begin
            r_state <= RND;
          end else begin
            r_state <= DONE;
            busy <= 1'b0;
            valid <= 1'b1;
            err <= 1'b0;
            root <= WIDTH'(w_root);
            rem <= WIDTH'(w_rem);
          end
        end
      end else if (r_state == RND) begin
        r_state <= DONE;
        busy <= 1'b0;
        valid <= 1'b1;
        err <= 1'b0;
        root <= WIDTH'(w_rnd);
        rem <= WIDTH'(r_rem);
      end
    end
  end
endmodule

// File: tb/tb_sqrt_fx_iter.sv
// tb_sqrt_fx_iter: four configurations (default, BPC=2, ROUND=1, SIGNED=1) checked against an arithmetic sqrt model.
module tb_sqrt_fx_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] rad = '0;
  logic start_a [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
  logic busy_a [4], valid_a [4], err_a [4];
  logic [15:0] root_a [4], rem_a [4];
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  sqrt_fx_iter u_def (.clk(clk), .rst(rst), .start(start_a[0]), .rad(rad), .busy(busy_a[0]), .valid(valid_a[0]), .err(err_a[0]), .root(root_a[0]), .rem(rem_a[0]));
  sqrt_fx_iter #(.BPC(2)) u_bpc2 (.clk(clk), .rst(rst), .start(start_a[1]), .rad(rad), .busy(busy_a[1]), .valid(valid_a[1]), .err(err_a[1]), .root(root_a[1]), .rem(rem_a[1]));
  sqrt_fx_iter #(.ROUND(1)) u_rnd (.clk(clk), .rst(rst), .start(start_a[2]), .rad(rad), .busy(busy_a[2]), .valid(valid_a[2]), .err(err_a[2]), .root(root_a[2]), .rem(rem_a[2]));
  sqrt_fx_iter #(.SIGNED(1)) u_sgn (.clk(clk), .rst(rst), .start(start_a[3]), .rad(rad), .busy(busy_a[3]), .valid(valid_a[3]), .err(err_a[3]), .root(root_a[3]), .rem(rem_a[3]));
  function automatic void model(input int d, input logic [15:0] v, output logic [15:0] r, output logic [15:0] m, output logic e, output int lat);
    longint x, s;
    x = longint'(v) << 8;
    s = longint'($floor($sqrt(real'(x))));
    while (s * s > x) s--;
    while ((s + 1) * (s + 1) <= x) s++;
    m = 16'(x - s * s);
    if (d == 2 && x - s * s > s && s < 4095) s++;
    r = 16'(s);
    e = 1'b0;
    lat = (d == 1 ? 6 : 12) + (d == 2 ? 1 : 0) + 1;
    if (d == 3 && v[15]) begin
      r = '0;
      m = '0;
      e = 1'b1;
      lat = 2;
    end
  endfunction
  task automatic run(input int d, input logic [15:0] v, input bit now, output int lat, output int bc, output logic [15:0] ro, output logic [15:0] re, output logic e);
    if (!now) @(negedge clk);
    rad = v;
    start_a[d] = 1'b1;
    @(negedge clk);
    start_a[d] = 1'b0;
    lat = 1;
    bc = 0;
    while (valid_a[d] !== 1'b1 && lat < 100) begin
      bc += (busy_a[d] === 1'b1) ? 1 : 0;
      @(negedge clk);
      lat++;
    end
    ro = root_a[d];
    re = rem_a[d];
    e = err_a[d];
    if (lat >= 100) begin
      checks++;
      failures++;
      $display("FAIL timeout dut=%0d rad=%h: no valid within 100 cycles", d, v);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    #100;
    for (int d = 0; d < 4; d++) begin
      checks++;
      if ({busy_a[d], valid_a[d], err_a[d], root_a[d], rem_a[d]} !== 35'd0) begin
        failures++;
        $display("FAIL reset dut=%0d got busy=%b valid=%b err=%b root=%h rem=%h, want all zero", d, busy_a[d], valid_a[d], err_a[d], root_a[d], rem_a[d]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_vectors();
    int td [10] = '{0, 0, 0, 0, 1, 2, 2, 0, 3, 3};
    logic [15:0] tv [10] = '{16'h0000, 16'hE890, 16'h0040, 16'h0200, 16'h0200, 16'h0003, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h0100};
    logic [15:0] tr [10] = '{16'h0000, 16'h0F40, 16'h0080, 16'h016A, 16'h016A, 16'h001C, 16'h0FFF, 16'h0FFF, 16'h0000, 16'h0100};
    logic [15:0] tm [10] = '{16'd0, 16'd0, 16'd0, 16'd28, 16'd28, 16'd39, 16'h1EFF, 16'h1EFF, 16'd0, 16'd0};
    int tl [10] = '{13, 13, 13, 13, 7, 14, 14, 13, 2, 13};
    int lat, bc;
    logic [15:0] ro, re;
    logic e;
    for (int i = 0; i < 10; i++) begin
      run(td[i], tv[i], 1'b0, lat, bc, ro, re, e);
      checks++;
      if (ro !== tr[i] || re !== tm[i] || e !== (tv[i] == 16'h8000) || lat != tl[i] || bc != tl[i] - 1) begin
        failures++;
        $display("FAIL vector%0d dut=%0d rad=%h got root=%h rem=%h err=%b lat=%0d busy=%0d, want root=%h rem=%h lat=%0d busy=%0d", i, td[i], tv[i], ro, re, e, lat, bc, tr[i], tm[i], tl[i], tl[i] - 1);
      end
      @(negedge clk);
      checks++;
      if (valid_a[td[i]] !== 1'b0 || root_a[td[i]] !== tr[i]) begin
        failures++;
        $display("FAIL hold%0d got valid=%b root=%h, want valid=0 root=%h", i, valid_a[td[i]], root_a[td[i]], tr[i]);
      end
    end
  endtask
  task automatic test_ignore_start();
    int lat = 0;
    @(negedge clk);
    rad = 16'h0200;
    start_a[0] = 1'b1;
    for (int n = 1; n < 40 && lat == 0; n++) begin
      @(negedge clk);
      if (valid_a[0] === 1'b1) lat = n;
      start_a[0] = (n == 3 || n == 7);
      rad = (n >= 3) ? 16'h0040 : 16'h0200;
    end
    start_a[0] = 1'b0;
    checks++;
    if (lat != 13 || root_a[0] !== 16'h016A || rem_a[0] !== 16'd28) begin
      failures++;
      $display("FAIL ignore_start got lat=%0d root=%h rem=%0d, want lat=13 root=016a rem=28", lat, root_a[0], rem_a[0]);
    end
  endtask
  task automatic test_reset_mid();
    int lat, bc, seen;
    logic [15:0] ro, re;
    logic e;
    @(negedge clk);
    rad = 16'h0200;
    start_a[0] = 1'b1;
    @(negedge clk);
    start_a[0] = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy_a[0], valid_a[0], err_a[0], root_a[0], rem_a[0]} !== 35'd0) begin
      failures++;
      $display("FAIL reset_mid got busy=%b valid=%b root=%h rem=%h, want all zero", busy_a[0], valid_a[0], root_a[0], rem_a[0]);
    end
    seen = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen += (valid_a[0] !== 1'b0 || busy_a[0] !== 1'b0) ? 1 : 0;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_discard got %0d cycles with valid/busy after reset, want 0", seen);
    end
    run(0, 16'h0040, 1'b0, lat, bc, ro, re, e);
    checks++;
    if (ro !== 16'h0080 || re !== 16'd0 || lat != 13) begin
      failures++;
      $display("FAIL after_reset got root=%h rem=%h lat=%0d, want root=0080 rem=0 lat=13", ro, re, lat);
    end
  endtask
  task automatic test_back_to_back();
    int lat, bc;
    logic [15:0] ro, re;
    logic e;
    run(0, 16'hE890, 1'b0, lat, bc, ro, re, e);
    run(0, 16'h0200, 1'b1, lat, bc, ro, re, e);
    checks++;
    if (ro !== 16'h016A || re !== 16'd28 || lat != 13 || bc != 12) begin
      failures++;
      $display("FAIL back_to_back got root=%h rem=%0d lat=%0d busy=%0d, want root=016a rem=28 lat=13 busy=12", ro, re, lat, bc);
    end
  endtask
  task automatic test_random();
    int lat, bc, xl;
    logic [15:0] v, ro, re, xr, xm;
    logic e, xe;
    for (int i = 0; i < 120; i++) begin
      int d = i % 4;
      v = 16'($urandom);
      if (i % 9 == 0) v = 16'($urandom_range(0, 3));
      model(d, v, xr, xm, xe, xl);
      run(d, v, 1'b0, lat, bc, ro, re, e);
      checks++;
      if (ro !== xr || re !== xm || e !== xe || lat != xl || bc != xl - 1) begin
        failures++;
        $display("FAIL random dut=%0d rad=%h got root=%h rem=%h err=%b lat=%0d, want root=%h rem=%h err=%b lat=%0d", d, v, ro, re, e, lat, xr, xm, xe, xl);
      end
    end
  endtask
  initial begin
    test_reset();
    test_vectors();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sqrt_fx_iter.md
Name: sqrt_fx_iter

Overview:
- Parametrised successor to the team's iterative restoring fixed-point square root.
- Computes root = floor or round(sqrt(rad)) in unsigned or signed Qm.FBITS format.
- Retires a configurable number of root bits per cycle and flags negative radicands.
- Sits in the fixed-point arithmetic unit beside the divider and multiplier, driven by a start/busy/valid handshake.

Parameters:
- WIDTH, 16: radicand/root word width. Q(WIDTH-FBITS).FBITS.
- FBITS, 8: fractional bits. WIDTH+FBITS must be even. FBITS <= WIDTH-2.
- BPC, 1: root bits per cycle, 1 or 2. With 2, ITER/BPC must be an integer.
- ROUND, 0: 0 = truncate, 1 = round-to-nearest. ROUND=1 adds one cycle.
- SIGNED, 0: 1 = rad is two's complement and negative input raises err.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- rad  in  WIDTH  radicand, captured on accepted start
- busy  out  1  calculation in progress
- valid  out  1  one-cycle pulse: root/rem/err valid
- err  out  1  negative radicand (SIGNED=1 only), qualified by valid
- root  out  WIDTH  result, Q format same as rad
- rem  out  WIDTH  unrounded integer remainder

Behaviour:
- ITER = (WIDTH+FBITS)/2 root bits. C = ITER/BPC compute cycles.
- Operand: X = rad << FBITS, a (WIDTH+FBITS)-bit unsigned integer.
- Result: r = isqrt(X), rem = X - r^2. 0 <= rem <= 2r. Root is zero-extended to WIDTH.
- Reset (async, any time, including mid-operation):
  - state to IDLE; busy=0, valid=0, err=0, root=0, rem=0.
  - In-flight operation is discarded and produces no valid.
- States: IDLE, CALC, RND (present only if ROUND=1), DONE.
- IDLE:
  - start=1 at edge E0: capture rad, clear the working root/remainder, go to CALC. busy=1 from E0.
- Negative radicand (SIGNED=1, rad[WIDTH-1]=1):
  - go directly to DONE instead.
  - After E1: valid=1, err=1, root=0, rem=0, busy=0.
- CALC:
  - Each cycle performs BPC restoring steps: trial subtract (rem<<2 | next 2 X bits) - (root<<2 | 1); keep the result if >= 0 and shift in a 1, else restore and shift in a 0.
  - After C cycles, go to RND if ROUND=1, else DONE.
- RND: if rem > r then root = r+1, saturating at 2^ITER-1. rem is not modified.
- DONE is a single cycle:
  - valid=1, busy=0, err=0. root/rem are registered outputs.
  - Next state IDLE, or CALC if start=1 this cycle (back-to-back accepted).
- Latency: valid is high in the cycle after edge E(C+ROUND) (E1 for the error path). busy is high for exactly C+ROUND cycles.
- start while busy=1: ignored entirely, and rad changes have no effect.
- root/rem/err hold their last values until the next DONE or reset. valid is never high for more than one consecutive cycle.
- BPC=2 result is bit-identical to BPC=1.

Test Plan:
- Defaults, rad=0x0000:
  - 100 ns in reset, release, start.
  - -> valid after E12, root=0x0000, rem=0, busy high for 12 cycles.
- Defaults, rad=0xE890 (232.5625) -> root=0x0F40 (15.25), rem=0.
- Defaults, rad=0x0040 -> root=0x0080, rem=0.
- Defaults, rad=0x0200 -> root=0x016A, rem=28.
- BPC=2, rad=0x0200 -> root=0x016A, rem=28, valid after E6.
- Defaults, start pulsed again at cycles 3 and 7 with rad=0x0040 -> ignored, result root=0x016A.
- ROUND=1:
  - rad=0x0003 -> root=0x001C, rem=39.
  - rad=0xFFFF -> root=0x0FFF saturated, rem=0x1EFF, valid after E13.
  - ROUND=0, rad=0xFFFF -> root=0x0FFF, rem=0x1EFF.
- SIGNED=1, rad=0x8000 -> valid after E1, err=1, root=0, rem=0.
  - Then rad=0x0100 -> err=0, root=0x0100.
- rst asserted at cycle 5 of an operation:
  - -> all outputs 0 immediately, no valid pulse.
  - After release, new start with rad=0x0040 -> root=0x0080.
  - Back-to-back: start held high in the DONE cycle -> second result 12 cycles later.
